// File: rtl/btb_pkg.sv
// Shared types and helpers for the BTB write-side scheduler.
package btb_pkg;

  localparam int unsigned BTB_IDX_W = 9;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] dest;
    logic        uncond;
  } btb_upd_t;

  typedef enum logic {StSweep, StRun} btb_ctrl_state_e;

  // Word-aligned branch PC to BTB set index; caller truncates to its index width.
  function automatic logic [63:0] btb_index(input logic [63:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Small circular FIFO holding pending BTB updates; push is refused when full.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int unsigned CntW = $clog2(QDEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  btb_upd_t        wdata,
  output btb_upd_t        rdata,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  btb_upd_t        mem_q [QDEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(QDEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full    = (cnt_q == CntW'(QDEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port scheduler: post-reset/flush invalidation sweep, then FIFO-ordered updates
// drained into predict-idle cycles, with a starvation cap forcing a write.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int unsigned IDX_W      = BTB_IDX_W,
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned STARVE_MAX = 8,
  localparam int unsigned CntW      = $clog2(QDEPTH + 1),
  localparam int unsigned StarveW   = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             flushReq,
  input  logic             predActive,
  input  logic             aValid,
  output logic             aReady,
  input  logic [63:0]      aPc,
  input  logic [63:0]      aDest,
  input  logic             aUncond,
  input  logic             bValid,
  output logic             bReady,
  input  logic [63:0]      bPc,
  input  logic [63:0]      bDest,
  input  logic             bUncond,
  output logic             btbWrEn,
  output logic [IDX_W-1:0] btbWrIdx,
  output logic [63:0]      btbWrPc,
  output logic [63:0]      btbWrDest,
  output logic             btbWrUncond,
  output logic             btbWrValid,
  output logic             busy,
  output logic [CntW-1:0]  qCount
);

  btb_ctrl_state_e state_q, state_d;
  logic [IDX_W-1:0]   sweep_idx_q, sweep_idx_d;
  logic [StarveW-1:0] starve_q, starve_d;

  logic       run_en;
  logic       sweep_wr;
  logic       starve_hit;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  btb_upd_t   upd_in;
  btb_upd_t   upd_head;

  logic             wr_en_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [63:0]      wr_pc_q;
  logic [63:0]      wr_dest_q;
  logic             wr_uncond_q;
  logic             wr_valid_q;

  assign run_en     = (state_q == StRun) & clkEn & ~flushReq;
  assign sweep_wr   = (state_q == StSweep) & ~flushReq;
  assign starve_hit = (starve_q == StarveW'(STARVE_MAX));
  assign upd_in     = aValid ? '{pc: aPc, dest: aDest, uncond: aUncond}
                             : '{pc: bPc, dest: bDest, uncond: bUncond};

  btb_upd_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clkEn & flushReq),
    .push  (push),
    .pop   (pop),
    .wdata (upd_in),
    .rdata (upd_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (qCount)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StSweep;
      sweep_idx_q <= '0;
      starve_q    <= '0;
    end else if (clkEn) begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      starve_q    <= starve_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    starve_d    = starve_q;
    if (flushReq) begin
      state_d     = StSweep;
      sweep_idx_d = '0;
      starve_d    = '0;
    end else begin
      unique case (state_q)
        StSweep: begin
          sweep_idx_d = sweep_idx_q + IDX_W'(1);
          starve_d    = '0;
          if (sweep_idx_q == '1) state_d = StRun;
        end
        StRun: begin
          if (pop || fifo_empty) starve_d = '0;
          else if (predActive && !starve_hit) starve_d = starve_q + StarveW'(1);
        end
        default: state_d = StSweep;
      endcase
    end
  end

  always_comb begin
    busy   = (state_q == StSweep);
    aReady = run_en & ~fifo_full;
    bReady = aReady & ~aValid;
    push   = (aValid & aReady) | (bValid & bReady);
    pop    = run_en & ~fifo_empty & (~predActive | starve_hit);
  end

  // Data fields load only on a write so a held strobe keeps its payload under clkEn=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      wr_pc_q     <= '0;
      wr_dest_q   <= '0;
      wr_uncond_q <= 1'b0;
      wr_valid_q  <= 1'b0;
    end else if (clkEn) begin
      wr_en_q <= sweep_wr | pop;
      if (sweep_wr) begin
        wr_idx_q    <= sweep_idx_q;
        wr_pc_q     <= '0;
        wr_dest_q   <= '0;
        wr_uncond_q <= 1'b0;
        wr_valid_q  <= 1'b0;
      end else if (pop) begin
        wr_idx_q    <= IDX_W'(btb_index(upd_head.pc, IDX_W));
        wr_pc_q     <= upd_head.pc;
        wr_dest_q   <= upd_head.dest;
        wr_uncond_q <= upd_head.uncond;
        wr_valid_q  <= 1'b1;
      end
    end
  end

  assign btbWrEn     = wr_en_q;
  assign btbWrIdx    = wr_idx_q;
  assign btbWrPc     = wr_pc_q;
  assign btbWrDest   = wr_dest_q;
  assign btbWrUncond = wr_uncond_q;
  assign btbWrValid  = wr_valid_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: vector table plus sweep/starvation/flush sequences.
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clkEn;
  logic        flushReq;
  logic        predActive;
  logic        aValid, aReady, aUncond;
  logic [63:0] aPc, aDest;
  logic        bValid, bReady, bUncond;
  logic [63:0] bPc, bDest;
  logic        btbWrEn, btbWrUncond, btbWrValid, busy;
  logic [3:0]  btbWrIdx;
  logic [63:0] btbWrPc, btbWrDest;
  logic [2:0]  qCount;

  btb_update_ctrl #(
    .IDX_W      (4),
    .QDEPTH     (4),
    .STARVE_MAX (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clkEn       (clkEn),
    .flushReq    (flushReq),
    .predActive  (predActive),
    .aValid      (aValid),
    .aReady      (aReady),
    .aPc         (aPc),
    .aDest       (aDest),
    .aUncond     (aUncond),
    .bValid      (bValid),
    .bReady      (bReady),
    .bPc         (bPc),
    .bDest       (bDest),
    .bUncond     (bUncond),
    .btbWrEn     (btbWrEn),
    .btbWrIdx    (btbWrIdx),
    .btbWrPc     (btbWrPc),
    .btbWrDest   (btbWrDest),
    .btbWrUncond (btbWrUncond),
    .btbWrValid  (btbWrValid),
    .busy        (busy),
    .qCount      (qCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [3:0]  idx;
    logic [63:0] pc;
    logic [63:0] dest;
    logic        unc;
    logic        valid;
    int          exp_cyc;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic        a_v;
    logic [63:0] a_pc;
    logic [63:0] a_dest;
    logic        a_unc;
    logic        b_v;
    logic [63:0] b_pc;
    logic [63:0] b_dest;
    logic        b_unc;
    logic        exp_a_rdy;
    logic        exp_b_rdy;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic push_upd(input logic [63:0] pc, input logic [63:0] dest, input logic unc,
                          input int exp_cyc);
    wr_t e;
    logic [63:0] word;
    word      = pc >> 2;
    e.idx     = word[3:0];
    e.pc      = pc;
    e.dest    = dest;
    e.unc     = unc;
    e.valid   = 1'b1;
    e.exp_cyc = exp_cyc;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 16; i++) begin
      wr_t e;
      e.idx = 4'(i); e.pc = '0; e.dest = '0; e.unc = 1'b0; e.valid = 1'b0; e.exp_cyc = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else begin
      $display("FAIL %s: %0d writes still pending, required 0 within %0d cycles",
               name, exp_q.size(), max_cyc);
      exp_q.delete();
    end
  endtask

  // A write commits at the next edge when strobe and clock enable are both high.
  always @(negedge clk) begin
    if (!rst && btbWrEn && clkEn) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got write idx=0x%0h pc=0x%0h required none (cycle %0d)",
                 btbWrIdx, btbWrPc, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_idx", 64'(btbWrIdx), 64'(e.idx));
        check("wr_pc", btbWrPc, e.pc);
        check("wr_dest", btbWrDest, e.dest);
        check("wr_uncond_valid", 64'({btbWrUncond, btbWrValid}), 64'({e.unc, e.valid}));
        if (e.exp_cyc != 0) check("wr_latency_cycle", 64'(cyc), 64'(e.exp_cyc));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 64'h1034, 64'h2000, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 64'h40, 64'h400, 1'b0, 1'b1, 64'h80, 64'h800, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0,
                64'hFEDC_BA98_7654_3210, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0,
                1'b1, 1'b0};
    vecs[4] = '{1'b1, 64'h1034, 64'h3000, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 64'h7C, 64'hA0, 1'b1, 1'b1, 64'h7C, 64'hB0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; clkEn = 1'b1; flushReq = 1'b0; predActive = 1'b0;
    aValid = 1'b1; aPc = 64'h40; aDest = '0; aUncond = 1'b0;
    bValid = 1'b1; bPc = 64'h80; bDest = '0; bUncond = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_wr_en", 64'(btbWrEn), 64'd0);
    check("rst_wr_idx_valid", 64'({btbWrIdx, btbWrValid}), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_ready", 64'({aReady, bReady}), 64'd0);
    check("rst_qcount", 64'(qCount), 64'd0);
    @(posedge clk); #1;
    aValid = 1'b0; bValid = 1'b0;
    push_sweep();
    @(posedge clk); #1;
    rst = 1'b0;

    // Initial sweep: busy drops while the idx 15 write is on the port
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (busy && k < 60);
      check("sweep_busy_fall", 64'(busy), 64'd0);
      check("sweep_last_write", 64'({btbWrEn, btbWrIdx}), 64'({1'b1, 4'hF}));
      check("sweep_aready_rise", 64'(aReady), 64'd1);
    end
    wait_drain("sweep_drain", 4);

    // Table-driven single and paired requests, predict port idle
    for (int v = 0; v < 6; v++) begin
      logic b_pend;
      int   n;
      @(posedge clk); #1;
      aValid = vecs[v].a_v; aPc = vecs[v].a_pc; aDest = vecs[v].a_dest;
      aUncond = vecs[v].a_unc;
      bValid = vecs[v].b_v; bPc = vecs[v].b_pc; bDest = vecs[v].b_dest;
      bUncond = vecs[v].b_unc;
      @(negedge clk);
      n = cyc;
      check($sformatf("vec%0d_aready", v), 64'(aReady), 64'(vecs[v].exp_a_rdy));
      check($sformatf("vec%0d_bready", v), 64'(bReady), 64'(vecs[v].exp_b_rdy));
      b_pend = vecs[v].a_v && vecs[v].b_v;
      if (vecs[v].a_v) push_upd(vecs[v].a_pc, vecs[v].a_dest, vecs[v].a_unc, n + 2);
      else if (vecs[v].b_v) push_upd(vecs[v].b_pc, vecs[v].b_dest, vecs[v].b_unc, n + 2);
      @(posedge clk); #1;
      aValid = 1'b0;
      if (!b_pend) bValid = 1'b0;
      if (b_pend) begin
        @(negedge clk);
        check($sformatf("vec%0d_bready_next", v), 64'(bReady), 64'd1);
        push_upd(vecs[v].b_pc, vecs[v].b_dest, vecs[v].b_unc, cyc + 2);
        @(posedge clk); #1;
        bValid = 1'b0;
      end
      wait_drain($sformatf("vec%0d_drain", v), 12);
    end

    // Starvation cap, twice to show the counter restarts after a forced write
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      predActive = 1'b1;
      aValid = 1'b1; aPc = 64'h200 + 64'(r * 4); aDest = 64'h900; aUncond = 1'b0;
      @(negedge clk);
      check("starve_aready", 64'(aReady), 64'd1);
      push_upd(aPc, aDest, aUncond, cyc + 10);
      @(posedge clk); #1;
      aValid = 1'b0;
      wait_drain("starve_drain", 20);
    end
    predActive = 1'b0;

    // Fill to capacity while predict port is busy
    @(posedge clk); #1;
    predActive = 1'b1;
    for (int i = 0; i < 5; i++) begin
      aValid = 1'b1; aPc = 64'h300 + 64'(i * 4); aDest = 64'h500 + 64'(i); aUncond = i[0];
      @(negedge clk);
      check($sformatf("fill%0d_aready", i), 64'(aReady), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) push_upd(aPc, aDest, aUncond, 0);
      else check("fill_qcount_full", 64'(qCount), 64'd4);
      @(posedge clk); #1;
    end
    aValid = 1'b0; predActive = 1'b0;
    wait_drain("fill_drain", 20);
    check("fill_qcount_empty", 64'(qCount), 64'd0);

    // Flush with queued updates, then again with a toggling clock enable
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clk); #1;
      predActive = 1'b1;
      for (int i = 0; i < 3; i++) begin
        aValid = 1'b1; aPc = 64'h600 + 64'(i * 4); aDest = 64'h700; aUncond = 1'b1;
        @(posedge clk); #1;
      end
      aValid = 1'b0;
      flushReq = 1'b1;
      if (pass == 1) begin
        clkEn = 1'b0;
        @(negedge clk);
        check("flush_gated_qcount", 64'(qCount), 64'd3);
        check("flush_gated_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        clkEn = 1'b1;
      end
      @(negedge clk);
      check($sformatf("flush%0d_aready", pass), 64'(aReady), 64'd0);
      @(posedge clk); #1;
      flushReq = 1'b0;
      if (pass == 1) clkEn = 1'b0;
      push_sweep();
      @(negedge clk);
      check($sformatf("flush%0d_qcount", pass), 64'(qCount), 64'd0);
      check($sformatf("flush%0d_busy", pass), 64'(busy), 64'd1);
      if (pass == 1) begin
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
          @(posedge clk); #1;
          clkEn = ~clkEn;
          @(negedge clk);
        end
        @(posedge clk); #1;
        clkEn = 1'b1;
      end
      predActive = 1'b0;
      wait_drain($sformatf("flush%0d_sweep", pass), 40);
      @(negedge clk);
      check($sformatf("flush%0d_done_busy", pass), 64'(busy), 64'd0);
      check($sformatf("flush%0d_done_qcount", pass), 64'(qCount), 64'd0);
    end

    // Normal operation resumes after a flush
    @(posedge clk); #1;
    bValid = 1'b1; bPc = 64'h1038; bDest = 64'h4444; bUncond = 1'b0;
    @(negedge clk);
    check("post_flush_bready", 64'(bReady), 64'd1);
    push_upd(bPc, bDest, bUncond, cyc + 2);
    @(posedge clk); #1;
    bValid = 1'b0;
    wait_drain("post_flush_drain", 12);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
